core_lsu: RTL and testbench

CORE_LSU -- requirements
Module: core_lsu

---
 rtl/core_lsu.sv | 168 ++++++++++++++++
 tb/tb_core_lsu.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
// core_lsu: load/store unit between the execute stage and a single-beat data bus.
//
// An accepted op is one of four kinds:
//   PASS      - ex_wdata_i is written back to ex_rd_i in the cycle after accept.
//   NOP       - nothing happens.
//   misaligned access - misalign_o pulses for one cycle, nothing else happens.
//   aligned load/store - a bus request is held until granted. Stores then
//     finish. Loads wait for the read response, then write back the
//     lane-selected and extended value.
// A new op is accepted only while idle.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   ex_vld_i / ex_ready_o        execute-stage handshake
//   ex_op_i, ex_addr_i, ex_wdata_i, ex_rd_i, ex_rd_we_i   operation fields
//   mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o  bus request
//   mem_gnt_i, mem_rvld_i, mem_rdata_i                      grant / read response
//   reg_waddr_o, reg_waddr_vld_o, reg_wdata_o               register-file write port
//   misalign_o                   one-cycle misaligned-access flag
module core_lsu #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int REG_BUS_WIDTH  = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ex_vld_i,
  output logic                      ex_ready_o,
  input  logic [3:0]                ex_op_i,
  input  logic [DATA_BUS_WIDTH-1:0] ex_addr_i,
  input  logic [DATA_BUS_WIDTH-1:0] ex_wdata_i,
  input  logic [REG_BUS_WIDTH-1:0]  ex_rd_i,
  input  logic                      ex_rd_we_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_BUS_WIDTH-1:0] mem_addr_o,
  output logic [3:0]                mem_be_o,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvld_i,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata_i,
  output logic [REG_BUS_WIDTH-1:0]  reg_waddr_o,
  output logic                      reg_waddr_vld_o,
  output logic [DATA_BUS_WIDTH-1:0] reg_wdata_o,
  output logic                      misalign_o
);
  localparam int W = DATA_BUS_WIDTH;

  localparam logic [3:0] OP_PASS = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW  = 4'd3,
                         OP_LBU  = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW   = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  // Per-transaction context kept while the bus access is in flight.
  typedef struct packed {
    logic [3:0]               op;
    logic [1:0]               off;
    logic [REG_BUS_WIDTH-1:0] rd;
    logic                     rd_we;
  } txn_t;

  state_t         state_q, state_d;
  txn_t           txn_q;
  logic           mem_we_q;
  logic           accept, is_mem, is_pass, mis, start_mem, load_done;
  logic [3:0]     st_be;
  logic [W-1:0]   st_data, ld_data;
  logic [7:0]     ld_b;
  logic [15:0]    ld_h;

  assign ex_ready_o = (state_q == IDLE);
  assign accept     = ex_vld_i & ex_ready_o;
  assign is_pass    = (ex_op_i == OP_PASS);
  assign is_mem     = (ex_op_i >= OP_LB) && (ex_op_i <= OP_SW);
  assign mis = (((ex_op_i == OP_LH) || (ex_op_i == OP_LHU) || (ex_op_i == OP_SH)) && ex_addr_i[0])
            || (((ex_op_i == OP_LW) || (ex_op_i == OP_SW)) && (ex_addr_i[1:0] != 2'b00));

  assign mem_req_o  = (state_q == REQ);
  assign mem_we_o   = mem_req_o & mem_we_q;

  // Stores place the narrow datum in every lane so the enables alone pick the target bytes.
  always_comb begin
    st_be   = 4'b1111;
    st_data = ex_wdata_i;
    case (ex_op_i)
      OP_SB: begin
        st_be   = 4'b0001 << ex_addr_i[1:0];
        st_data = {(W/8){ex_wdata_i[7:0]}};
      end
      OP_SH: begin
        st_be   = 4'b0011 << {ex_addr_i[1], 1'b0};
        st_data = {(W/16){ex_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension from the captured address offset.
  always_comb begin
    ld_b    = mem_rdata_i[8*txn_q.off +: 8];
    ld_h    = mem_rdata_i[16*txn_q.off[1] +: 16];
    ld_data = mem_rdata_i;
    case (txn_q.op)
      OP_LB:   ld_data = {{(W-8){ld_b[7]}}, ld_b};
      OP_LH:   ld_data = {{(W-16){ld_h[15]}}, ld_h};
      OP_LBU:  ld_data = {{(W-8){1'b0}}, ld_b};
      OP_LHU:  ld_data = {{(W-16){1'b0}}, ld_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_mem = 1'b0;
    load_done = 1'b0;
    case (state_q)
      IDLE: if (accept && is_mem && !mis) begin
        state_d   = REQ;
        start_mem = 1'b1;
      end
      REQ:  if (mem_gnt_i) state_d = (txn_q.op >= OP_SB) ? IDLE : RESP;
      RESP: if (mem_rvld_i) begin
        state_d   = IDLE;
        load_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      txn_q           <= '0;
      mem_we_q        <= 1'b0;
      mem_addr_o      <= '0;
      mem_be_o        <= '0;
      mem_wdata_o     <= '0;
      reg_waddr_o     <= '0;
      reg_waddr_vld_o <= 1'b0;
      reg_wdata_o     <= '0;
      misalign_o      <= 1'b0;
    end else begin
      reg_waddr_vld_o <= 1'b0;
      misalign_o      <= accept & is_mem & mis;
      if (accept && is_pass && ex_rd_we_i && (ex_rd_i != '0)) begin
        reg_waddr_vld_o <= 1'b1;
        reg_waddr_o     <= ex_rd_i;
        reg_wdata_o     <= ex_wdata_i;
      end
      if (start_mem) begin
        txn_q       <= '{op: ex_op_i, off: ex_addr_i[1:0], rd: ex_rd_i, rd_we: ex_rd_we_i};
        mem_we_q    <= (ex_op_i >= OP_SB);
        mem_addr_o  <= {ex_addr_i[W-1:2], 2'b00};
        mem_be_o    <= st_be;
        mem_wdata_o <= st_data;
      end
      if (load_done) begin
        reg_waddr_vld_o <= txn_q.rd_we && (txn_q.rd != '0);
        reg_waddr_o     <= txn_q.rd;
        reg_wdata_o     <= ld_data;
      end
    end
  end
endmodule

// File: tb/tb_core_lsu.sv
// Bench for core_lsu: transaction-level model plus directed vectors with literal expectations.
module tb_core_lsu;
  logic        clk_i = 1'b0, rst_i;
  logic        ex_vld_i, ex_ready_o, ex_rd_we_i;
  logic [3:0]  ex_op_i;
  logic [31:0] ex_addr_i, ex_wdata_i;
  logic [4:0]  ex_rd_i;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvld_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_waddr_vld_o, misalign_o;
  logic [31:0] reg_wdata_o;

  core_lsu #(.DATA_BUS_WIDTH(32), .REG_BUS_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ex_vld_i(ex_vld_i), .ex_ready_o(ex_ready_o),
    .ex_op_i(ex_op_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_rd_i(ex_rd_i),
    .ex_rd_we_i(ex_rd_we_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvld_i(mem_rvld_i), .mem_rdata_i(mem_rdata_i),
    .reg_waddr_o(reg_waddr_o), .reg_waddr_vld_o(reg_waddr_vld_o), .reg_wdata_o(reg_wdata_o),
    .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int acc_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit misaligned(input logic [3:0] op, input logic [31:0] a);
    int s = acc_size(op);
    return (s > 1) && ((a % s) != 0);
  endfunction

  function automatic logic [31:0] load_val(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] v = d >> (8 * (a % 4));
    case (op)
      4'd1: return ((v & 32'hFF) >= 32'h80) ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
      4'd2: return ((v & 32'hFFFF) >= 32'h8000) ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
      4'd4: return v & 32'hFF;
      4'd5: return v & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_be(input logic [3:0] op, input logic [31:0] a);
    if (op < 4'd6) return 32'hF;
    return ((32'd1 << acc_size(op)) - 1) << (a % 4);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [3:0] op, input logic [31:0] d);
    case (op)
      4'd6:    return (d & 32'hFF) * 32'h0101_0101;
      4'd7:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  logic        m_pend, m_granted, m_we, e_wb, e_mis;
  logic [3:0]  m_op;
  logic [31:0] m_addr, m_wd, e_data;
  logic [4:0]  m_rd, e_rd;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_pend <= 0; m_granted <= 0; e_wb <= 0; e_mis <= 0;
    end else begin
      e_wb  <= 0;
      e_mis <= 0;
      if (!m_pend) begin
        if (ex_vld_i) begin
          if (misaligned(ex_op_i, ex_addr_i)) e_mis <= 1;
          else if (ex_op_i == 4'd0) begin
            if (ex_rd_we_i && ex_rd_i != 0) begin
              e_wb <= 1; e_rd <= ex_rd_i; e_data <= ex_wdata_i;
            end
          end else if (ex_op_i <= 4'd8) begin
            m_pend <= 1; m_granted <= 0; m_op <= ex_op_i; m_addr <= ex_addr_i;
            m_wd <= ex_wdata_i; m_rd <= ex_rd_i; m_we <= ex_rd_we_i;
          end
        end
      end else if (!m_granted) begin
        if (mem_gnt_i) begin
          if (m_op >= 4'd6) m_pend <= 0;
          else m_granted <= 1;
        end
      end else if (mem_rvld_i) begin
        m_pend <= 0; m_granted <= 0;
        if (m_we && m_rd != 0) begin
          e_wb <= 1; e_rd <= m_rd; e_data <= load_val(m_op, m_addr, mem_rdata_i);
        end
      end
    end
  end

  always @(negedge clk_i) if (chk_en) begin
    chk("ex_ready", {31'd0, ex_ready_o}, {31'd0, !m_pend});
    chk("mem_req", {31'd0, mem_req_o}, {31'd0, m_pend && !m_granted});
    chk("wb_vld", {31'd0, reg_waddr_vld_o}, {31'd0, e_wb});
    chk("misalign", {31'd0, misalign_o}, {31'd0, e_mis});
    if (e_wb) begin
      chk("wb_rd", {27'd0, reg_waddr_o}, {27'd0, e_rd});
      chk("wb_data", reg_wdata_o, e_data);
    end
    if (m_pend && !m_granted) begin
      chk("mem_addr", mem_addr_o, m_addr & ~32'd3);
      chk("mem_we", {31'd0, mem_we_o}, {31'd0, m_op >= 4'd6});
      chk("mem_be", {28'd0, mem_be_o}, exp_be(m_op, m_addr));
      if (m_op >= 4'd6) chk("mem_wdata", mem_wdata_o, exp_wd(m_op, m_wd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk_i); #2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic we);
    ex_vld_i = 1; ex_op_i = op; ex_addr_i = a; ex_wdata_i = d; ex_rd_i = rd; ex_rd_we_i = we;
    cyc();
    ex_vld_i = 0;
  endtask

  task automatic grant(input int w);
    repeat (w) cyc();
    mem_gnt_i = 1; cyc(); mem_gnt_i = 0;
  endtask

  task automatic respond(input int w, input logic [31:0] d);
    repeat (w) cyc();
    mem_rvld_i = 1; mem_rdata_i = d; cyc(); mem_rvld_i = 0;
  endtask

  initial begin
    rst_i = 1; ex_vld_i = 0; ex_op_i = 0; ex_addr_i = 0; ex_wdata_i = 0; ex_rd_i = 0;
    ex_rd_we_i = 0; mem_gnt_i = 0; mem_rvld_i = 0; mem_rdata_i = 0;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_wbvld", {31'd0, reg_waddr_vld_o}, 32'd0);
    chk("rst_wdata", reg_wdata_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    chk_en = 1;
    rst_i = 0; cyc();

    // PASS, then exactly one pulse
    issue(4'd0, 32'h0, 32'h1234_5678, 5'd5, 1);
    chk("pass_vld", {31'd0, reg_waddr_vld_o}, 32'd1);
    chk("pass_rd", {27'd0, reg_waddr_o}, 32'd5);
    chk("pass_data", reg_wdata_o, 32'h1234_5678);
    cyc();
    chk("pass_pulse_end", {31'd0, reg_waddr_vld_o}, 32'd0);

    // rd==0 / we==0 / NOP: no writeback
    issue(4'd0, 32'h0, 32'hDEAD_BEEF, 5'd0, 1);
    chk("pass_rd0", {31'd0, reg_waddr_vld_o}, 32'd0);
    issue(4'd0, 32'h0, 32'hDEAD_BEEF, 5'd3, 0);
    chk("pass_we0", {31'd0, reg_waddr_vld_o}, 32'd0);
    issue(4'd9, 32'h40, 32'h1, 5'd3, 1);
    chk("nop_req", {31'd0, mem_req_o}, 32'd0);

    // back-to-back PASS: second accept during first writeback
    issue(4'd0, 32'h0, 32'hAAAA_0001, 5'd1, 1);
    issue(4'd0, 32'h0, 32'hBBBB_0002, 5'd2, 1);
    chk("b2b_data", reg_wdata_o, 32'hBBBB_0002);
    cyc();

    // LB with 2-cycle waits on grant and response
    issue(4'd1, 32'h103, 32'h0, 5'd7, 1);
    chk("lb_addr", mem_addr_o, 32'h100);
    chk("lb_we", {31'd0, mem_we_o}, 32'd0);
    rst_i = 0; mem_rvld_i = 1; mem_rdata_i = 32'h5555_5555; cyc(); mem_rvld_i = 0; // ignored in REQ
    grant(1);
    respond(2, 32'h80FF_FFFF);
    chk("lb_data", reg_wdata_o, 32'hFFFF_FF80);
    chk("lb_vld", {31'd0, reg_waddr_vld_o}, 32'd1);

    // LHU, minimum latency; next op accepted during its writeback
    issue(4'd5, 32'h102, 32'h0, 5'd8, 1);
    grant(0);
    respond(0, 32'h8001_0000);
    chk("lhu_lat_vld", {31'd0, reg_waddr_vld_o}, 32'd1);
    chk("lhu_data", reg_wdata_o, 32'h0000_8001);
    issue(4'd2, 32'h100, 32'h0, 5'd9, 1);      // LH, accepted in writeback cycle
    grant(0);
    respond(1, 32'h1234_8001);
    chk("lh_data", reg_wdata_o, 32'hFFFF_8001);
    issue(4'd4, 32'h101, 32'h0, 5'd10, 1);     // LBU
    grant(0);
    respond(0, 32'h0000_FE00);
    chk("lbu_data", reg_wdata_o, 32'h0000_00FE);
    issue(4'd3, 32'h204, 32'h0, 5'd0, 1);      // LW to rd 0: no writeback
    grant(0);
    respond(0, 32'hCAFE_F00D);
    chk("lw_rd0", {31'd0, reg_waddr_vld_o}, 32'd0);

    // stores
    issue(4'd6, 32'h201, 32'h0000_00AB, 5'd4, 1);
    chk("sb_be", {28'd0, mem_be_o}, 32'b0010);
    chk("sb_wdata", mem_wdata_o, 32'hABAB_ABAB);
    chk("sb_we", {31'd0, mem_we_o}, 32'd1);
    grant(1);
    chk("sb_nowb", {31'd0, reg_waddr_vld_o}, 32'd0);
    chk("sb_ready", {31'd0, ex_ready_o}, 32'd1);
    issue(4'd7, 32'h202, 32'h1234_CDEF, 5'd4, 1);
    chk("sh_be", {28'd0, mem_be_o}, 32'b1100);
    chk("sh_wdata", mem_wdata_o, 32'hCDEF_CDEF);
    grant(0);
    issue(4'd8, 32'h300, 32'h0BAD_F00D, 5'd4, 1);
    chk("sw_be", {28'd0, mem_be_o}, 32'b1111);
    grant(0);

    // rvld while idle is ignored
    mem_rvld_i = 1; cyc(); mem_rvld_i = 0;
    chk("idle_rvld", {31'd0, reg_waddr_vld_o}, 32'd0);

    // misaligned
    issue(4'd3, 32'h302, 32'h0, 5'd6, 1);
    chk("lw_mis", {31'd0, misalign_o}, 32'd1);
    chk("lw_mis_req", {31'd0, mem_req_o}, 32'd0);
    chk("lw_mis_ready", {31'd0, ex_ready_o}, 32'd1);
    cyc();
    chk("lw_mis_pulse", {31'd0, misalign_o}, 32'd0);
    issue(4'd7, 32'h101, 32'h0, 5'd6, 1);
    chk("sh_mis", {31'd0, misalign_o}, 32'd1);
    issue(4'd1, 32'h101, 32'h0, 5'd6, 0);      // LB never misaligned
    chk("lb_odd_ok", {31'd0, mem_req_o}, 32'd1);
    grant(0);
    respond(0, 32'h0);

    // reset in RESP abandons the load
    issue(4'd3, 32'h400, 32'h0, 5'd9, 1);
    grant(0);
    rst_i = 1; cyc();
    chk("rst_resp_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_resp_ready", {31'd0, ex_ready_o}, 32'd1);
    rst_i = 0;
    respond(0, 32'h7777_7777);
    chk("rst_resp_nowb", {31'd0, reg_waddr_vld_o}, 32'd0);

    // reset in REQ abandons the store; later grant ignored
    issue(4'd8, 32'h500, 32'h1, 5'd1, 1);
    rst_i = 1; cyc(); rst_i = 0;
    grant(0);
    chk("rst_req_idle", {31'd0, mem_req_o}, 32'd0);
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
